// File: rtl/common_pkg.sv
// Shared simulation constants for stream benches.
// Upper bound on packet size generated by bench tasks.
package common_pkg;

    localparam int MAX_SIM_BYTS = 512;

endpackage

// File: rtl/if_axi_stream.sv
// AXI-stream style bundle with sink/source views.
// One beat transfers when val && rdy on a rising clock edge.
interface if_axi_stream #(
    parameter int DAT_BYTS = 64,
    parameter int CTL_BITS = 8,
    parameter int MOD_BITS = (DAT_BYTS == 1) ? 1 : $clog2(DAT_BYTS)
);

    logic                  val;
    logic                  rdy;
    logic                  err;
    logic                  sop;
    logic                  eop;
    logic [CTL_BITS-1:0]   ctl;
    logic [DAT_BYTS*8-1:0] dat;
    logic [MOD_BITS-1:0]   mod;

    modport sink (
        input  val, err, sop, eop, ctl, dat, mod,
        output rdy
    );

    modport source (
        output val, err, sop, eop, ctl, dat, mod,
        input  rdy
    );

endinterface

// File: rtl/modport_reg_slice.sv
// Full-throughput stream register slice: main register plus one skid entry.
// Upstream rdy is registered and depends only on skid occupancy.
module modport_reg_slice #(
    parameter int DAT_BYTS = 64,
    parameter int CTL_BITS = 8,
    parameter int MOD_BITS = (DAT_BYTS == 1) ? 1 : $clog2(DAT_BYTS)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    if_axi_stream.sink    i_axi,
    if_axi_stream.source  o_axi
);

    localparam int DAT_BITS = DAT_BYTS * 8;

    typedef struct packed {
        logic                val;
        logic                err;
        logic                sop;
        logic                eop;
        logic [CTL_BITS-1:0] ctl;
        logic [DAT_BITS-1:0] dat;
        logic [MOD_BITS-1:0] mod;
    } if_t;

    if_t  main_q, main_d;
    if_t  skid_q, skid_d;
    if_t  in_beat;
    logic rdy_q, rdy_d;
    logic in_fire;
    logic out_fire;

    always_comb begin
        in_beat     = '0;
        in_beat.val = 1'b1;
        in_beat.err = i_axi.err;
        in_beat.sop = i_axi.sop;
        in_beat.eop = i_axi.eop;
        in_beat.ctl = i_axi.ctl;
        in_beat.dat = i_axi.dat;
        in_beat.mod = i_axi.mod;
    end

    assign in_fire  = i_axi.val & rdy_q;
    assign out_fire = main_q.val & o_axi.rdy;

    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (skid_q.val) begin
            if (out_fire) begin
                main_d     = skid_q;
                skid_d.val = 1'b0;
            end
        end else if (!main_q.val || out_fire) begin
            if (in_fire) begin
                main_d = in_beat;
            end else begin
                // Data fields keep their last value while idle.
                main_d.val = 1'b0;
            end
        end else if (in_fire) begin
            skid_d = in_beat;
        end
        rdy_d = ~skid_d.val;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            main_q <= '0;
            skid_q <= '0;
            rdy_q  <= 1'b0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
            rdy_q  <= rdy_d;
        end
    end

    assign i_axi.rdy = rdy_q;
    assign o_axi.val = main_q.val;
    assign o_axi.err = main_q.err;
    assign o_axi.sop = main_q.sop;
    assign o_axi.eop = main_q.eop;
    assign o_axi.ctl = main_q.ctl;
    assign o_axi.dat = main_q.dat;
    assign o_axi.mod = main_q.mod;

endmodule

// File: tb/tb_modport_reg_slice.sv
// Self-checking bench for modport_reg_slice.
// Vector table for cycle-exact states, scoreboard for stream integrity.
module tb_modport_reg_slice;
    import common_pkg::*;

    localparam int DB = 64;
    localparam int CB = 8;
    localparam int MB = 6;

    typedef struct packed {
        logic          err;
        logic          sop;
        logic          eop;
        logic [CB-1:0] ctl;
        logic [DB*8-1:0] dat;
        logic [MB-1:0] mod;
    } beat_t;

    typedef struct {
        logic       in_val;
        logic [7:0] tag;
        logic       o_rdy;
        logic       e_val;
        logic [7:0] e_tag;
        logic       e_rdy;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    if_axi_stream #(.DAT_BYTS(DB), .CTL_BITS(CB), .MOD_BITS(MB)) i_if ();
    if_axi_stream #(.DAT_BYTS(DB), .CTL_BITS(CB), .MOD_BITS(MB)) o_if ();

    modport_reg_slice #(
        .DAT_BYTS(DB),
        .CTL_BITS(CB),
        .MOD_BITS(MB)
    ) dut (
        .i_clk(clk),
        .i_rst(rst_n),
        .i_axi(i_if),
        .o_axi(o_if)
    );

    int    checks = 0;
    int    errors = 0;
    int    n_out  = 0;
    bit    rand_rdy = 1'b0;
    beat_t sbq[$];

    task automatic chk(string nm, logic [599:0] got, logic [599:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic beat_t out_beat();
        beat_t b;
        b = {o_if.err, o_if.sop, o_if.eop, o_if.ctl, o_if.dat, o_if.mod};
        return b;
    endfunction

    function automatic beat_t in_beat();
        beat_t b;
        b = {i_if.err, i_if.sop, i_if.eop, i_if.ctl, i_if.dat, i_if.mod};
        return b;
    endfunction

    task automatic drive(beat_t b, logic v);
        i_if.val = v;
        {i_if.err, i_if.sop, i_if.eop, i_if.ctl, i_if.dat, i_if.mod} = b;
    endtask

    function automatic beat_t mk_beat(int n, int k);
        beat_t b;
        int nb;
        nb = (n + DB - 1) / DB;
        b = '0;
        b.sop = (k == 0);
        b.eop = (k == nb - 1);
        b.err = 1'($urandom_range(0, 1));
        b.ctl = CB'($urandom);
        for (int j = 0; j < DB; j++)
            if (k * DB + j < n)
                b.dat[8*j +: 8] = 8'($urandom);
        b.mod = b.eop ? MB'(n % DB) : '0;
        return b;
    endfunction

    // Scoreboard: sample at negedge the handshakes of the coming edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (i_if.val && i_if.rdy)
                sbq.push_back(in_beat());
            if (o_if.val && o_if.rdy) begin
                n_out++;
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got extra beat expected none");
                end else begin
                    chk("sb_beat", 600'(out_beat()), 600'(sbq.pop_front()));
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            o_if.rdy = 1'($urandom_range(0, 1));
        end
    end

    task automatic put_beat(beat_t b, output int cyc);
        bit done;
        done = 1'b0;
        cyc = 0;
        drive(b, 1'b1);
        while (!done) begin
            @(negedge clk);
            done = i_if.rdy;
            @(posedge clk);
            #1;
            cyc++;
            if (!done && cyc > 2000) begin
                checks++;
                errors++;
                $display("FAIL put_timeout: got no rdy expected rdy");
                done = 1'b1;
            end
        end
        i_if.val = 1'b0;
    endtask

    task automatic put_stream(int n, bit gaps);
        int nb;
        int c;
        nb = (n + DB - 1) / DB;
        for (int k = 0; k < nb; k++) begin
            put_beat(mk_beat(n, k), c);
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic drain(string nm);
        int t;
        t = 0;
        while (sbq.size() > 0 && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk(nm, 600'(sbq.size()), 600'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vt[11];
        beat_t b0, b1, ba, bb, bc;
        int    c, sum, n0;

        vt[0]  = '{1'b1, 8'd1, 1'b0, 1'b1, 8'd1, 1'b1};
        vt[1]  = '{1'b1, 8'd2, 1'b0, 1'b1, 8'd1, 1'b0};
        vt[2]  = '{1'b1, 8'd3, 1'b0, 1'b1, 8'd1, 1'b0};
        vt[3]  = '{1'b1, 8'd3, 1'b1, 1'b1, 8'd2, 1'b1};
        vt[4]  = '{1'b1, 8'd3, 1'b1, 1'b1, 8'd3, 1'b1};
        vt[5]  = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd3, 1'b1};
        vt[6]  = '{1'b0, 8'd0, 1'b0, 1'b0, 8'd3, 1'b1};
        vt[7]  = '{1'b1, 8'd4, 1'b1, 1'b1, 8'd4, 1'b1};
        vt[8]  = '{1'b1, 8'd5, 1'b1, 1'b1, 8'd5, 1'b1};
        vt[9]  = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd5, 1'b1};
        vt[10] = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd5, 1'b1};

        // Reset with traffic offered upstream.
        b0 = mk_beat(64, 0);
        drive(b0, 1'b1);
        o_if.rdy = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_oval", 600'(o_if.val), 600'(0));
        chk("rst_fields", 600'(out_beat()), 600'(0));
        chk("rst_irdy", 600'(i_if.rdy), 600'(0));
        i_if.val = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rdy_after_rst", 600'(i_if.rdy), 600'(1));

        // Cycle-exact state table.
        for (int i = 0; i < 11; i++) begin
            b0 = '0;
            b0.dat[7:0] = vt[i].tag;
            b0.ctl = vt[i].tag;
            drive(b0, vt[i].in_val);
            o_if.rdy = vt[i].o_rdy;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_oval", i), 600'(o_if.val), 600'(vt[i].e_val));
            chk($sformatf("vec%0d_tag", i), 600'(o_if.dat[7:0]), 600'(vt[i].e_tag));
            chk($sformatf("vec%0d_irdy", i), 600'(i_if.rdy), 600'(vt[i].e_rdy));
        end
        i_if.val = 1'b0;
        o_if.rdy = 1'b1;
        drain("vec_drain");

        // 100-byte packet, latency 1, mod of last beat.
        b0 = mk_beat(100, 0);
        b1 = mk_beat(100, 1);
        put_beat(b0, c);
        chk("pkt_lat1_val", 600'(o_if.val), 600'(1));
        chk("pkt_b0", 600'(out_beat()), 600'(b0));
        put_beat(b1, c);
        chk("pkt_eop", 600'(o_if.eop), 600'(1));
        chk("pkt_mod", 600'(o_if.mod), 600'(36));
        chk("pkt_b1", 600'(out_beat()), 600'(b1));
        @(posedge clk);
        #1;
        chk("pkt_idle", 600'(o_if.val), 600'(0));
        drain("pkt_drain");

        // Backpressure: three beats offered, two buffered.
        ba = mk_beat(192, 0);
        bb = mk_beat(192, 1);
        bc = mk_beat(192, 2);
        o_if.rdy = 1'b0;
        put_beat(ba, c);
        put_beat(bb, c);
        chk("bp_one_cycle", 600'(c), 600'(1));
        drive(bc, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("bp_irdy_low", 600'(i_if.rdy), 600'(0));
            chk("bp_stable", 600'(out_beat()), 600'(ba));
            @(posedge clk);
            #1;
        end
        o_if.rdy = 1'b1;
        put_beat(bc, c);
        drain("bp_drain");

        // Random packets with random downstream rdy.
        rand_rdy = 1'b1;
        for (int p = 0; p < 1000; p++)
            put_stream($urandom_range(1, MAX_SIM_BYTS), 1'b1);
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        o_if.rdy = 1'b1;
        drain("rand_drain");

        // Full throughput.
        n0 = n_out;
        sum = 0;
        for (int k = 0; k < 64; k++) begin
            put_beat(mk_beat(64 * 64, k), c);
            sum += c;
        end
        chk("tput_cycles", 600'(sum), 600'(64));
        repeat (2) @(posedge clk);
        #1;
        chk("tput_beats", 600'(n_out - n0), 600'(64));
        drain("tput_drain");

        // Reset with two beats buffered.
        o_if.rdy = 1'b0;
        put_beat(mk_beat(128, 0), c);
        put_beat(mk_beat(128, 1), c);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_oval", 600'(o_if.val), 600'(0));
        chk("mid_rst_fields", 600'(out_beat()), 600'(0));
        chk("mid_rst_irdy", 600'(i_if.rdy), 600'(0));
        sbq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        o_if.rdy = 1'b1;
        n0 = n_out;
        put_stream(150, 1'b0);
        drain("mid_rst_drain");
        chk("mid_rst_beats", 600'(n_out - n0), 600'(3));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
